lif_spike_rate_decoder: RTL
===========================

Name: lif_spike_rate_decoder

Overview:
Downstream consumer of the LIF neuron's spike output. It converts the spike pulse train into two measurements:
- a spike count per programmable window, delivered over a valid/ready handshake;
- an inter-spike-interval (ISI) measurement, delivered as a one-cycle pulse.

It sits between the neuron core and the output mux / readout logic of the top-level project.

Parameters:
CNT_W, 8, width of the per-window spike count (saturating)
WIN_W, 16, width of the window-length field
ISI_W, 12, width of the ISI measurement (saturating)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  run enable; 0 aborts the current window and returns to IDLE
spike_in  input  1  neuron spike output; only rising edges count as events
win_len  input  WIN_W  window length in cycles, latched on IDLE->COUNT; 0 treated as 1
rate_ready  input  1  consumer accepts rate_count
rate_valid  output  1  rate_count holds an unaccepted window result
rate_count  output  CNT_W  spikes counted in the last completed window
rate_overrun  output  1  sticky: an unaccepted result was overwritten
isi_valid  output  1  one-cycle pulse, isi updated
isi  output  ISI_W  cycles between the last two spike events
busy  output  1  high while in COUNT

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. All outputs are 0: rate_valid, rate_count, rate_overrun, isi_valid, isi, busy. The edge-detect register is 0.
- Event definition: ev = spike_in & ~spike_q, where spike_q is the registered spike_in. A level held high counts once.
- State IDLE:
  - win_cnt, spike_cnt, isi_timer and isi_armed are cleared.
  - en=1 -> COUNT next cycle. On that transition, latch win_len_q=max(win_len,1) and clear rate_overrun.
- State COUNT (busy=1). Cycle 0 is the first COUNT cycle.
  - win_cnt increments every cycle.
  - On ev, spike_cnt increments, saturating at 2^CNT_W-1.
  - On the cycle where win_cnt==win_len_q-1, on the next edge:
    - rate_count <= sat(spike_cnt + ev) and rate_valid <= 1;
    - win_cnt and spike_cnt restart at 0;
    - windows run back-to-back with no gap.
  - rate_valid therefore first rises on cycle win_len_q.
  - en=0 -> IDLE next cycle. The partial window is discarded and no rate_valid is produced. A pending rate_valid/rate_count is held untouched.
- Handshake rules:
  - rate_valid stays high until an edge where rate_valid&rate_ready; it drops on the next cycle.
  - rate_count is stable while rate_valid=1, except on overwrite.
  - Window end with rate_valid=1 and rate_ready=0: rate_count is overwritten, rate_valid stays 1, rate_overrun <= 1 (sticky).
  - Window end in the same cycle as acceptance: new value loaded, rate_valid stays 1, no overrun.
- ISI measurement:
  - isi_timer counts cycles in COUNT, saturating at 2^ISI_W-1. It runs across window boundaries.
  - On ev with isi_armed=0: set isi_armed and reset isi_timer to 0; no output.
  - On ev with isi_armed=1: isi <= isi_timer+1 (saturating), isi_valid pulses on the next cycle, isi_timer resets to 0.
  - Example: events on cycles t and t+5 give isi=5.
- rst mid-operation overrides everything; any pending result is lost.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package lif_pkg holds:
  - state enum (IDLE, COUNT);
  - default widths CNT_W/WIN_W/ISI_W;
  - saturating-increment function.
- Sub-module lif_isi_timer contains the edge detect, armed flag, saturating timer and isi/isi_valid registers. It is instantiated once.
- Window counter, FSM and handshake stay in the top module.

Test Plan:
- win_len=10, en=1, rate_ready=1, one-cycle spikes on cycles 2, 5, 9:
  - rate_valid high on cycle 10 with rate_count=3, low on cycle 11;
  - isi=3 then isi=4, each with a single isi_valid pulse.
- spike_in held high for 20 cycles, win_len=50 -> rate_count=1, no isi_valid.
- CNT_W=8, spike toggled every cycle (50 events), win_len=400 -> rate_count=50.
  - Rerun with win_len=600 and 300 events -> rate_count=255 (saturated).
- win_len=4, rate_ready=0 for 3 windows -> rate_valid stays 1, rate_count shows the latest window, rate_overrun=1.
  - rate_ready=1 -> rate_valid drops; rate_overrun stays 1 until the next IDLE->COUNT.
- en dropped on cycle 6 of a win_len=10 window with 2 spikes -> no rate_valid, busy=0 next cycle.
  - Re-enable -> the count restarts from 0.
- win_len=0 -> behaves as 1: rate_valid is produced every cycle; with rate_ready=1 rate_count = spike event that cycle.
  - Also: ISI_W=4, spikes 30 cycles apart -> isi=15.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types, default widths and helpers for the LIF spike-rate decoder.
package lif_pkg;

  localparam int unsigned DefCntW = 8;
  localparam int unsigned DefWinW = 16;
  localparam int unsigned DefIsiW = 12;

  typedef enum logic [0:0] {
    StIdle,
    StCount
  } lif_state_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/lif_spike_rate_decoder_if.sv
// Valid/ready channel carrying the per-window spike count.
interface lif_spike_rate_decoder_if #(
  parameter int unsigned CNT_W = lif_pkg::DefCntW
) ();

  logic             rate_valid;
  logic             rate_ready;
  logic [CNT_W-1:0] rate_count;

  modport master (
    output rate_valid,
    output rate_count,
    input  rate_ready
  );

  modport slave (
    input  rate_valid,
    input  rate_count,
    output rate_ready
  );

endinterface

// File: rtl/lif_isi_timer.sv
// Spike edge detector and inter-spike-interval measurement.
module lif_isi_timer
  import lif_pkg::*;
#(
  parameter int unsigned ISI_W = DefIsiW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_i,
  input  logic             run_i,    // active counting cycle
  input  logic             clear_i,  // idle: drop arm flag and timer
  output logic             ev_o,
  output logic             isi_valid_o,
  output logic [ISI_W-1:0] isi_o
);

  localparam logic [31:0] IsiMax = 32'((64'd1 << ISI_W) - 64'd1);

  logic             spike_q;
  logic             armed_q, armed_d;
  logic [ISI_W-1:0] timer_q, timer_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;

  assign ev_o        = spike_i & ~spike_q;
  assign isi_valid_o = isi_valid_q;
  assign isi_o       = isi_q;

  // Next-state for arm flag, saturating timer and measurement.
  always_comb begin
    armed_d     = armed_q;
    timer_d     = timer_q;
    isi_d       = isi_q;
    isi_valid_d = 1'b0;
    if (clear_i) begin
      armed_d = 1'b0;
      timer_d = '0;
    end else if (run_i) begin
      if (ev_o) begin
        timer_d = '0;
        armed_d = 1'b1;
        if (armed_q) begin
          isi_d       = ISI_W'(sat_inc(32'(timer_q), IsiMax));
          isi_valid_d = 1'b1;
        end
      end else begin
        timer_d = ISI_W'(sat_inc(32'(timer_q), IsiMax));
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q     <= 1'b0;
      armed_q     <= 1'b0;
      timer_q     <= '0;
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
    end else begin
      spike_q     <= spike_i;
      armed_q     <= armed_d;
      timer_q     <= timer_d;
      isi_q       <= isi_d;
      isi_valid_q <= isi_valid_d;
    end
  end

endmodule

// File: rtl/lif_spike_rate_decoder.sv
// Converts a spike train into per-window counts (valid/ready) and ISI pulses.
module lif_spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned WIN_W = DefWinW,
  parameter int unsigned ISI_W = DefIsiW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   spike_in,
  input  logic [WIN_W-1:0]       win_len,
  lif_spike_rate_decoder_if.master rate_if,
  output logic                   rate_overrun,
  output logic                   isi_valid,
  output logic [ISI_W-1:0]       isi,
  output logic                   busy
);

  localparam logic [31:0] CntMax = 32'((64'd1 << CNT_W) - 64'd1);

  lif_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
  logic [CNT_W-1:0] spike_cnt_ev;
  logic             rate_valid_q, rate_valid_d;
  logic [CNT_W-1:0] rate_count_q, rate_count_d;
  logic             overrun_q, overrun_d;
  logic             ev;
  logic             run;
  logic             win_end;

  assign run     = (state_q == StCount) && en;
  assign win_end = run && (win_cnt_q == (win_len_q - WIN_W'(1)));

  lif_isi_timer #(
    .ISI_W (ISI_W)
  ) u_isi (
    .clk         (clk),
    .rst         (rst),
    .spike_i     (spike_in),
    .run_i       (run),
    .clear_i     (state_q == StIdle),
    .ev_o        (ev),
    .isi_valid_o (isi_valid),
    .isi_o       (isi)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: en alone moves between idle and counting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en)  state_d = StCount;
      StCount: if (!en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StCount);
  end

  // Window counter, spike counter and result handshake.
  always_comb begin
    win_len_d    = win_len_q;
    win_cnt_d    = win_cnt_q;
    spike_cnt_d  = spike_cnt_q;
    overrun_d    = overrun_q;
    spike_cnt_ev = ev ? CNT_W'(sat_inc(32'(spike_cnt_q), CntMax)) : spike_cnt_q;
    // Acceptance first; a simultaneous window end reloads below.
    rate_valid_d = rate_valid_q & ~rate_if.rate_ready;
    rate_count_d = rate_count_q;

    if (state_q == StIdle) begin
      win_cnt_d   = '0;
      spike_cnt_d = '0;
      if (en) begin
        win_len_d = (win_len == '0) ? WIN_W'(1) : win_len;
        overrun_d = 1'b0;
      end
    end else if (run) begin
      if (win_end) begin
        win_cnt_d   = '0;
        spike_cnt_d = '0;
      end else begin
        win_cnt_d   = win_cnt_q + WIN_W'(1);
        spike_cnt_d = spike_cnt_ev;
      end
    end

    if (win_end) begin
      rate_count_d = spike_cnt_ev;
      rate_valid_d = 1'b1;
      if (rate_valid_q && !rate_if.rate_ready) overrun_d = 1'b1;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_len_q    <= WIN_W'(1);
      win_cnt_q    <= '0;
      spike_cnt_q  <= '0;
      rate_valid_q <= 1'b0;
      rate_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      win_len_q    <= win_len_d;
      win_cnt_q    <= win_cnt_d;
      spike_cnt_q  <= spike_cnt_d;
      rate_valid_q <= rate_valid_d;
      rate_count_q <= rate_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rate_if.rate_valid = rate_valid_q;
  assign rate_if.rate_count = rate_count_q;
  assign rate_overrun       = overrun_q;

endmodule
